// File: rtl/div_clk_monitor_if.sv
// rtl/div_clk_monitor_if.sv - divided-clock monitor signal bundle
interface div_clk_monitor_if #(
  parameter int CW = 16
);
  logic          clk_in;
  logic [CW-1:0] exp_period;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          meas_valid;
  logic          err;
  logic          locked;
  logic          stuck;

  modport master (
    output clk_in, exp_period,
    input  period_o, high_o, meas_valid, err, locked, stuck
  );

  modport slave (
    input  clk_in, exp_period,
    output period_o, high_o, meas_valid, err, locked, stuck
  );
endinterface

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures period/high time of a divided clock sampled in clk
module div_clk_monitor #(
  parameter int CW       = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  div_clk_monitor_if.slave mon
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);
  localparam logic [MW-1:0] LOCK_VAL = MW'(LOCK_CNT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t        state_q, state_d;
  logic          in_q, in_d;
  logic          in_qq, in_qq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic [MW-1:0] match_q, match_d;
  logic          meas_valid_q, meas_valid_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic          stuck_q, stuck_d;
  logic          rise;
  logic          mismatch;

  assign rise     = in_q & ~in_qq;
  assign mismatch = (mon.exp_period != '0) && (cnt_q != mon.exp_period);

  always_comb begin
    state_d      = state_q;
    in_d         = mon.clk_in;
    in_qq_d      = in_q;
    period_d     = period_q;
    high_d       = high_q;
    match_d      = match_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked_q;
    stuck_d      = stuck_q;

    // Counters run in both states; a rise always restarts the interval.
    if (rise) begin
      cnt_d  = CW'(1);
      hcnt_d = CW'(1);
    end else begin
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      hcnt_d = (hcnt_q == CNT_MAX || !in_q) ? hcnt_q : hcnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
          stuck_d = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d     = cnt_q;
          high_d       = hcnt_q;
          meas_valid_d = 1'b1;
          if (mismatch) begin
            err_d    = 1'b1;
            match_d  = '0;
            locked_d = 1'b0;
          end else begin
            match_d = (match_q == LOCK_VAL) ? match_q : match_q + MW'(1);
            if (match_d == LOCK_VAL) locked_d = 1'b1;
          end
        end else if (cnt_q == TO_VAL) begin
          // Partial interval is dropped; the next rise only re-arms.
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_q         <= 1'b1;
      in_qq        <= 1'b1;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      match_q      <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_q         <= in_d;
      in_qq        <= in_qq_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      match_q      <= match_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
    end
  end

  assign mon.period_o   = period_q;
  assign mon.high_o     = high_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.err        = err_q;
  assign mon.locked     = locked_q;
  assign mon.stuck      = stuck_q;
endmodule
